mdu_hilo: RTL

MDU_HILO -- requirements
Module: mdu_hilo

---
 rtl/mdu_hilo.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mdu_hilo.sv
// HI/LO multiply-divide unit: single-cycle registered multiply, 32-iteration
// restoring divide, MTHI/MTLO writes and a combinational stall request.
module mdu_hilo (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  EXE_MDUOp,
    input  logic [31:0] EXE_Src1,
    input  logic [31:0] EXE_Src2,
    input  logic        EXE_Flush,
    input  logic        EXE_Hold,
    output logic        EXE_MDUBusy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        HILO_Wr
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned DW   = 2 * XLEN;
    localparam int unsigned CNTW = 6;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]   prod_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic            q_neg_q, r_neg_q;
    logic [CNTW-1:0] cnt_q;

    logic start_mul, start_div, div_step, mul_wr, div_wr, mt_hi, mt_lo;

    // Operand conditioning for the start cycle
    logic            is_signed, src1_neg, src2_neg;
    logic [XLEN-1:0] abs1, abs2;
    logic [DW-1:0]   mul_a, mul_b, mul_p;

    always_comb begin
        is_signed = (EXE_MDUOp == OP_MULT) || (EXE_MDUOp == OP_DIV);
        src1_neg  = is_signed & EXE_Src1[XLEN-1];
        src2_neg  = is_signed & EXE_Src2[XLEN-1];
        abs1      = src1_neg ? -EXE_Src1 : EXE_Src1;
        abs2      = src2_neg ? -EXE_Src2 : EXE_Src2;
        // Low 64 bits of the extended product are correct for both signednesses
        mul_a     = {{XLEN{src1_neg}}, EXE_Src1};
        mul_b     = {{XLEN{src2_neg}}, EXE_Src2};
        mul_p     = mul_a * mul_b;
    end

    // One restoring iteration and the final sign fix-up
    logic [XLEN:0]   div_tmp, div_diff;
    logic            div_ge, div_last;
    logic [XLEN-1:0] div_rem_n, div_quo_n, div_hi, div_lo;

    always_comb begin
        div_tmp   = {rem_q, quo_q[XLEN-1]};
        div_diff  = div_tmp - {1'b0, dvs_q};
        div_ge    = div_tmp >= {1'b0, dvs_q};
        div_rem_n = div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0];
        div_quo_n = {quo_q[XLEN-2:0], div_ge};
        div_hi    = r_neg_q ? -div_rem_n : div_rem_n;
        div_lo    = q_neg_q ? -div_quo_n : div_quo_n;
        div_last  = (cnt_q == CNTW'(XLEN - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        EXE_MDUBusy = 1'b0;
        start_mul   = 1'b0;
        start_div   = 1'b0;
        div_step    = 1'b0;
        mul_wr      = 1'b0;
        div_wr      = 1'b0;
        mt_hi       = 1'b0;
        mt_lo       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!EXE_Flush) begin
                    case (EXE_MDUOp)
                        OP_MULT, OP_MULTU: begin
                            start_mul   = 1'b1;
                            EXE_MDUBusy = 1'b1;
                            state_d     = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            start_div   = 1'b1;
                            EXE_MDUBusy = 1'b1;
                            state_d     = ST_DIV;
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (EXE_Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    EXE_MDUBusy = 1'b1;
                    mul_wr      = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DIV: begin
                if (EXE_Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    EXE_MDUBusy = 1'b1;
                    div_step    = 1'b1;
                    if (div_last) begin
                        div_wr  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Held instruction must not restart, so the opcode is ignored here
                if (EXE_Flush || !EXE_Hold) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!resetn) EXE_MDUBusy = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= '0;
            HI      <= '0;
            LO      <= '0;
            HILO_Wr <= 1'b0;
        end else begin
            HILO_Wr <= 1'b0;
            if (start_mul) prod_q <= mul_p;
            if (start_div) begin
                rem_q   <= '0;
                quo_q   <= abs1;
                dvs_q   <= abs2;
                q_neg_q <= src1_neg ^ src2_neg;
                r_neg_q <= src1_neg;
                cnt_q   <= '0;
            end else if (div_step) begin
                rem_q   <= div_rem_n;
                quo_q   <= div_quo_n;
                cnt_q   <= cnt_q + CNTW'(1);
            end
            if (mul_wr) begin
                HI      <= prod_q[DW-1:XLEN];
                LO      <= prod_q[XLEN-1:0];
                HILO_Wr <= 1'b1;
            end
            if (div_wr) begin
                HI      <= div_hi;
                LO      <= div_lo;
                HILO_Wr <= 1'b1;
            end
            if (mt_hi) begin
                HI      <= EXE_Src1;
                HILO_Wr <= 1'b1;
            end
            if (mt_lo) begin
                LO      <= EXE_Src1;
                HILO_Wr <= 1'b1;
            end
        end
    end

endmodule
